// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_e    : fetch FSM states (IDLE / WAIT / DROP)
//   RESET_PC_DEFAULT : default boot vector
//   fetch_entry_t    : queue entry {pc, instr}
//   pc_plus4         : sequential next-PC helper (wraps mod 2^32)
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request outstanding
    WAIT = 2'd1,  // request outstanding, returned word is wanted
    DROP = 2'd2   // request outstanding, returned word belongs to a flushed stream
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] cur);
    return cur + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory request/acknowledge bus.
//   req   : request, held until ack
//   addr  : word address, stable while req=1
//   ack   : one-cycle response strobe
//   rdata : instruction word, valid with ack
// Modports: master (fetch side), slave (memory side).
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: small synchronous FIFO of {pc, instr} entries.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   push, push_data   : enqueue an entry (accepted when not full, or full with pop)
//   pop               : dequeue the head (ignored when empty)
//   flush             : empty the queue; wins over push and pop
//   head              : head entry, all-zero when empty
//   count             : current occupancy
//   count_next        : occupancy after this cycle's push/pop/flush
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // a full queue still accepts a push when the head leaves in the same cycle
    do_push  = push && ((count_q != DEPTH_C) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage carries no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction fetch stage.
// Holds the fetch PC, issues word requests over imem (req/ack), buffers
// returned words with their PCs in fetch_queue and presents the head to decode.
// Redirects flush the queue and discard any in-flight response.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   imem (master)       : instruction memory request bus
//   redirect_en/_pc     : taken branch/jump pulse and target (bits [1:0] ignored)
//   id_ready            : decode consumes the head entry this cycle
//   instr_valid/instr/pc: queue head (instr/pc are zero when empty)
// Optional (macro FETCH_PERF_EN):
//   perf_fetched        : count of words pushed into the queue
//   perf_bubble         : count of cycles with decode ready but no instruction
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master imem,
  input  logic         redirect_en,
  input  logic [31:0]  redirect_pc,
  input  logic         id_ready,
  output logic         instr_valid,
  output logic [31:0]  instr,
  output logic [31:0]  pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_bubble
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;

  logic          push, pop, flush, has_space, issue;
  logic [31:0]   redirect_pc_al;
  fetch_entry_t  push_entry, head;
  logic [CW-1:0] q_count, q_count_next;

  // Queue control: a redirect flushes and suppresses both push and pop.
  assign redirect_pc_al   = {redirect_pc[31:2], 2'b00};
  assign flush            = redirect_en;
  assign pop              = instr_valid && id_ready && !redirect_en;
  assign push             = (state_q == WAIT) && imem.ack && !redirect_en;
  assign push_entry.pc    = fetch_pc_q;
  assign push_entry.instr = imem.rdata;
  // space is judged on the post-update occupancy so a pop frees a slot at once
  assign has_space        = q_count_next < DEPTH_C;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .flush      (flush),
    .head       (head),
    .count      (q_count),
    .count_next (q_count_next)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (has_space) state_d = WAIT;
      // on ack with a same-cycle redirect the queue is flushed, so has_space
      // holds and the redirect target goes out back-to-back
      WAIT: begin
        if (imem.ack) begin
          if (!has_space) state_d = IDLE;
        end else if (redirect_en) begin
          state_d = DROP;
        end
      end
      DROP: if (imem.ack) state_d = WAIT;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    req_d      = req_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    if (push)        fetch_pc_d = pc_plus4(fetch_pc_q);
    if (redirect_en) fetch_pc_d = redirect_pc_al;
    // a new request starts whenever the bus is free and we land in WAIT;
    // an unacked request keeps its address even across a redirect
    issue = (state_d == WAIT) && ((state_q == IDLE) || imem.ack);
    if (issue) begin
      req_d  = 1'b1;
      addr_d = fetch_pc_d;
    end else if (state_d == IDLE) begin
      req_d  = 1'b0;
    end
  end

  assign imem.req    = req_q;
  assign imem.addr   = addr_q;
  assign instr_valid = (q_count != '0);
  assign instr       = head.instr;
  assign pc          = head.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;

  always_comb begin
    perf_fetched_d = push ? perf_fetched_q + 32'd1 : perf_fetched_q;
    perf_bubble_d  = (!instr_valid && id_ready) ? perf_bubble_q + 32'd1 : perf_bubble_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_bubble_q  <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubble_q  <= perf_bubble_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubble  = perf_bubble_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// A behavioural memory answers requests after a programmable latency; every
// word that should survive is pushed to a scoreboard queue and compared when
// decode consumes it. Redirects flush the scoreboard.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubble;
`endif

  fetch_unit_if imem ();

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .id_ready    (id_ready),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_bubble (perf_bubble)
`endif
  );

  always #5 clk = ~clk;

  int           n_total = 0;
  int           n_bad   = 0;
  fetch_entry_t sb[$];
  logic [31:0]  stream_pc;
  logic         dropping;
  int           wait_cnt;
  int           lat;
  logic         hold_prev;
  logic [31:0]  hold_addr;
  int           exp_fetched;
  int           exp_bubble;
  logic         ready_v;
  logic         redir_v;
  logic [31:0]  redir_pc_v;
  logic         a;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs, update the model, advance.
  task automatic cycle(output logic acked);
    fetch_entry_t e;
    logic ack_now;
    ack_now     = imem.req && (wait_cnt >= lat);
    imem.ack    = ack_now;
    imem.rdata  = ack_now ? mem_word(imem.addr) : 32'h0BAD_F00D;
    redirect_en = redir_v;
    redirect_pc = redir_pc_v;
    id_ready    = ready_v;

    if (hold_prev) begin
      check("req_hold", 32'(imem.req), 32'd1);
      check("addr_hold", imem.addr, hold_addr);
    end

    check("valid", 32'(instr_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("head_pc", pc, sb[0].pc);
      check("head_instr", instr, sb[0].instr);
      if (ready_v && !redir_v) begin
        e = sb.pop_front();
        $display("pop pc=%h instr=%h", e.pc, e.instr);
      end
    end else begin
      check("empty_instr", instr, 32'h0);
      check("empty_pc", pc, 32'h0);
      if (ready_v) exp_bubble++;
    end

    if (ack_now) begin
      if (redir_v || dropping) begin
        dropping = 1'b0;
      end else begin
        check("ack_addr", imem.addr, stream_pc);
        e.pc    = stream_pc;
        e.instr = mem_word(stream_pc);
        sb.push_back(e);
        stream_pc = stream_pc + 32'd4;
        exp_fetched++;
      end
    end
    if (redir_v) begin
      sb.delete();
      stream_pc = {redir_pc_v[31:2], 2'b00};
      if (imem.req && !ack_now) dropping = 1'b1;
    end

    hold_prev = imem.req && !ack_now;
    hold_addr = imem.addr;
    if (imem.req && !ack_now) wait_cnt++;
    else wait_cnt = 0;
    redir_v = 1'b0;
    acked   = ack_now;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fresh_req();
    for (int i = 0; i < 20; i++) begin
      if (imem.req && wait_cnt == 0) break;
      cycle(a);
    end
    if (!(imem.req && wait_cnt == 0)) check("wait_req", 32'(imem.req && wait_cnt == 0), 32'd1);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redir_v    = 1'b1;
    redir_pc_v = target;
  endtask

  initial begin
    rst = 1'b1;
    redirect_en = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    imem.ack = 1'b0; imem.rdata = '0;
    ready_v = 1'b0; redir_v = 1'b0; redir_pc_v = '0;
    stream_pc = RPC; dropping = 1'b0; wait_cnt = 0; lat = 0;
    hold_prev = 1'b0; hold_addr = '0; exp_fetched = 0; exp_bubble = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(imem.req), 32'd0);
    check("rst_addr", imem.addr, RPC);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", pc, 32'h0);

    // back-to-back streaming from the reset vector
    rst = 1'b0; ready_v = 1'b1; lat = 0;
    cycle(a);
    for (int i = 0; i < 3; i++) begin
      check("seq_req", 32'(imem.req), 32'd1);
      check("seq_addr", imem.addr, RPC + 32'(4 * i));
      cycle(a);
    end

    // decode stalls: queue fills to DEPTH and requests stop
    ready_v = 1'b0;
    repeat (5) cycle(a);
    check("full_req", 32'(imem.req), 32'd0);
    check("full_cnt", 32'(sb.size()), 32'(DEPTH));
    ready_v = 1'b1;
    repeat (6) cycle(a);

    // redirect while a slow request is outstanding
    lat = 3;
    wait_fresh_req();
    redirect_to(32'h0000_1002);
    cycle(a);
    check("drop_valid", 32'(instr_valid), 32'd0);
    a = 1'b0;
    for (int i = 0; i < 10 && !a; i++) cycle(a);
    check("drop_ack_seen", 32'(a), 32'd1);
    check("drop_next_req", 32'(imem.req), 32'd1);
    check("drop_next_addr", imem.addr, 32'h0000_1000);
    lat = 0;
    repeat (4) cycle(a);

    // redirect coinciding with the ack
    wait_fresh_req();
    redirect_to(32'h0000_2000);
    cycle(a);
    check("same_req", 32'(imem.req), 32'd1);
    check("same_addr", imem.addr, 32'h0000_2000);
    repeat (3) cycle(a);

    // wrap past the top of the address space
    wait_fresh_req();
    redirect_to(32'hFFFF_FFFC);
    cycle(a);
    check("wrap_addr0", imem.addr, 32'hFFFF_FFFC);
    cycle(a);
    check("wrap_addr1", imem.addr, 32'h0000_0000);
    repeat (4) cycle(a);

    // redirect while idle with a full queue
    ready_v = 1'b0;
    repeat (4) cycle(a);
    check("idle_req", 32'(imem.req), 32'd0);
    redirect_to(32'h0000_3000);
    cycle(a);
    check("idle_redir_req", 32'(imem.req), 32'd1);
    check("idle_redir_addr", imem.addr, 32'h0000_3000);
    ready_v = 1'b1;
    repeat (4) cycle(a);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      lat     = $urandom_range(0, 2);
      ready_v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) redirect_to($urandom);
      cycle(a);
    end

`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, 32'(exp_fetched));
    check("perf_bubble", perf_bubble, 32'(exp_bubble));
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
